// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// STATUS/CTRL bit positions and the TX/RX state encodings.
package uart_pkg;

  // Byte offsets inside the UART window
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_BAUD   = 4'hC;

  // STATUS bit positions
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_FULL     = 2;
  localparam int ST_RX_EMPTY    = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_FRAME_ERR   = 5;
  localparam int ST_PARITY_ERR  = 6;
  localparam int ST_TX_OVERFLOW = 7;
  localparam int ST_TX_BUSY     = 8;

  // CTRL bit positions
  localparam int CT_TX_EN      = 0;
  localparam int CT_RX_EN      = 1;
  localparam int CT_PARITY_EN  = 2;
  localparam int CT_PARITY_ODD = 3;
  localparam int CT_RX_IRQ_EN  = 4;
  localparam int CT_TX_IRQ_EN  = 5;

  // Ticks per bit time
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. Push and pop may happen in
// the same cycle at any fill level; a push into a full FIFO is only
// accepted when a pop frees the slot in that same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB tells full (MSBs differ) from empty (identical)
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate them
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Pointer update, wrapping naturally modulo 2*DEPTH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, optional
// parity, sticky W1C error flags and a registered level interrupt.
module uart_mmio_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 27,
  parameter int DIV_W       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic        uart_wr_enable,
  input  logic        uart_rd_enable,
  output logic [31:0] uart_rdata,
  output logic        uart_irq,
  input  logic        rx_bit,
  output logic        tx_bit
);

  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);

  // Register file state
  logic [5:0]       ctrl_reg;
  logic [DIV_W-1:0] baud_reg;
  logic             rx_overrun_reg, frame_err_reg, parity_err_reg, tx_overflow_reg;
  logic             irq_reg;

  // Tick generator
  logic [DIV_W-1:0] tick_cnt_reg;
  logic [DIV_W-1:0] baud_eff;
  logic             tick;

  // FIFO interfaces
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  // TX path
  tx_state_e  tx_state_reg;
  logic [3:0] tx_os_reg;
  logic [2:0] tx_idx_reg;
  logic [7:0] tx_shift_reg;
  logic       tx_par_reg, tx_par_en_reg, tx_bit_reg;
  logic       tx_busy;

  // RX path
  logic       rx_s1_reg, rx_s2_reg, rx_prev_reg;
  rx_state_e  rx_state_reg;
  logic [3:0] rx_os_reg;
  logic [2:0] rx_idx_reg;
  logic [7:0] rx_shift_reg;
  logic       rx_par_en_reg, rx_par_odd_reg, rx_par_bit_reg;
  logic       rx_push_reg;
  logic [7:0] rx_byte_reg;
  logic       frame_err_pulse_reg, parity_err_pulse_reg;

  // Address decode and strobes
  logic       sel_data, sel_status, sel_ctrl, sel_baud;
  logic [3:0] w1c;
  logic       overrun_set, tx_overflow_set;
  logic [31:0] status;
  logic       unused_wdata;

  assign sel_data   = (uart_addr == ADDR_DATA);
  assign sel_status = (uart_addr == ADDR_STATUS);
  assign sel_ctrl   = (uart_addr == ADDR_CTRL);
  assign sel_baud   = (uart_addr == ADDR_BAUD);

  assign tx_push = uart_wr_enable && sel_data;
  assign rx_pop  = uart_rd_enable && sel_data && !rx_empty;
  assign tx_pop  = (tx_state_reg == TX_IDLE) && tick && ctrl_reg[CT_TX_EN] && !tx_empty;

  assign w1c             = (uart_wr_enable && sel_status) ? uart_wdata[7:4] : 4'b0;
  assign overrun_set     = rx_push_reg && rx_full && !rx_pop;
  assign tx_overflow_set = tx_push && tx_full && !tx_pop;
  assign tx_busy         = (tx_state_reg != TX_IDLE);
  assign unused_wdata    = ^uart_wdata[31:DIV_W];

  assign status = {23'b0, tx_busy, tx_overflow_reg, parity_err_reg, frame_err_reg,
                   rx_overrun_reg, rx_empty, rx_full, tx_empty, tx_full};

  assign baud_eff = (baud_reg == '0) ? DIV_W'(1) : baud_reg;
  assign tick     = (tick_cnt_reg == '0);
  assign tx_bit   = tx_bit_reg;
  assign uart_irq = irq_reg;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset),
    .push(tx_push), .push_data(uart_wdata[7:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset),
    .push(rx_push_reg), .push_data(rx_byte_reg), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Combinational read mux; reflects state before any same-cycle write
  always_comb begin
    uart_rdata = '0;
    case (uart_addr)
      ADDR_DATA:   uart_rdata = rx_empty ? 32'b0 : {24'b0, rx_head};
      ADDR_STATUS: uart_rdata = status;
      ADDR_CTRL:   uart_rdata = {26'b0, ctrl_reg};
      ADDR_BAUD:   uart_rdata = 32'(baud_reg);
      default:     uart_rdata = '0;
    endcase
  end

  // Free-running tick counter; a new divisor is picked up at the next reload
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= baud_eff - DIV_W'(1);
    else           tick_cnt_reg <= tick_cnt_reg - DIV_W'(1);
  end

  // CTRL/BAUD writes, sticky flags (set beats W1C) and the interrupt level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_reg        <= 6'h03;
      baud_reg        <= DIV_W'(DEFAULT_DIV);
      rx_overrun_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      parity_err_reg  <= 1'b0;
      tx_overflow_reg <= 1'b0;
      irq_reg         <= 1'b0;
    end else begin
      if (uart_wr_enable && sel_ctrl) ctrl_reg <= uart_wdata[5:0];
      if (uart_wr_enable && sel_baud) baud_reg <= uart_wdata[DIV_W-1:0];
      rx_overrun_reg  <= overrun_set          | (rx_overrun_reg  & ~w1c[0]);
      frame_err_reg   <= frame_err_pulse_reg  | (frame_err_reg   & ~w1c[1]);
      parity_err_reg  <= parity_err_pulse_reg | (parity_err_reg  & ~w1c[2]);
      tx_overflow_reg <= tx_overflow_set      | (tx_overflow_reg & ~w1c[3]);
      irq_reg <= (ctrl_reg[CT_RX_IRQ_EN] & ~rx_empty) | (ctrl_reg[CT_TX_IRQ_EN] & tx_empty);
    end
  end

  // TX FSM: each non-idle state lasts one bit time of 16 ticks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_reg  <= TX_IDLE;
      tx_os_reg     <= '0;
      tx_idx_reg    <= '0;
      tx_shift_reg  <= '0;
      tx_par_reg    <= 1'b0;
      tx_par_en_reg <= 1'b0;
      tx_bit_reg    <= 1'b1;
    end else if (tx_state_reg == TX_IDLE) begin
      tx_bit_reg <= 1'b1;
      if (tx_pop) begin
        tx_state_reg  <= TX_START;
        tx_bit_reg    <= 1'b0;
        tx_shift_reg  <= tx_head;
        tx_par_reg    <= ^tx_head ^ ctrl_reg[CT_PARITY_ODD];
        tx_par_en_reg <= ctrl_reg[CT_PARITY_EN];
        tx_os_reg     <= '0;
        tx_idx_reg    <= '0;
      end
    end else if (tick) begin
      if (tx_os_reg == OS_LAST) begin
        tx_os_reg <= '0;
        case (tx_state_reg)
          TX_START: begin
            tx_state_reg <= TX_DATA;
            tx_bit_reg   <= tx_shift_reg[0];
          end
          TX_DATA: begin
            if (tx_idx_reg == 3'd7) begin
              tx_state_reg <= tx_par_en_reg ? TX_PARITY : TX_STOP;
              tx_bit_reg   <= tx_par_en_reg ? tx_par_reg : 1'b1;
            end else begin
              tx_idx_reg   <= tx_idx_reg + 3'd1;
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_bit_reg   <= tx_shift_reg[1];
            end
          end
          TX_PARITY: begin
            tx_state_reg <= TX_STOP;
            tx_bit_reg   <= 1'b1;
          end
          TX_STOP: begin
            tx_state_reg <= TX_IDLE;
            tx_bit_reg   <= 1'b1;
          end
          default: tx_state_reg <= TX_IDLE;
        endcase
      end else begin
        tx_os_reg <= tx_os_reg + 4'd1;
      end
    end
  end

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rx_bit;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  // RX FSM: start on a falling edge, sample mid-bit, validate stop and parity
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_reg         <= RX_IDLE;
      rx_os_reg            <= '0;
      rx_idx_reg           <= '0;
      rx_shift_reg         <= '0;
      rx_par_en_reg        <= 1'b0;
      rx_par_odd_reg       <= 1'b0;
      rx_par_bit_reg       <= 1'b0;
      rx_push_reg          <= 1'b0;
      rx_byte_reg          <= '0;
      frame_err_pulse_reg  <= 1'b0;
      parity_err_pulse_reg <= 1'b0;
    end else begin
      rx_push_reg          <= 1'b0;
      frame_err_pulse_reg  <= 1'b0;
      parity_err_pulse_reg <= 1'b0;
      if (!ctrl_reg[CT_RX_EN]) begin
        rx_state_reg <= RX_IDLE;
        rx_os_reg    <= '0;
      end else if (rx_state_reg == RX_IDLE) begin
        // A stuck-low line after a framing error produces no edge, so we wait here
        if (rx_prev_reg && !rx_s2_reg) begin
          rx_state_reg   <= RX_START;
          rx_os_reg      <= '0;
          rx_idx_reg     <= '0;
          rx_par_en_reg  <= ctrl_reg[CT_PARITY_EN];
          rx_par_odd_reg <= ctrl_reg[CT_PARITY_ODD];
        end
      end else if (tick) begin
        rx_os_reg <= rx_os_reg + 4'd1;
        if (rx_os_reg == OS_MID) begin
          case (rx_state_reg)
            RX_START:  if (rx_s2_reg) rx_state_reg <= RX_IDLE;
            RX_DATA:   rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
            RX_PARITY: rx_par_bit_reg <= rx_s2_reg;
            RX_STOP: begin
              rx_state_reg <= RX_IDLE;
              if (!rx_s2_reg) begin
                frame_err_pulse_reg <= 1'b1;
              end else if (rx_par_en_reg &&
                           (rx_par_bit_reg != (^rx_shift_reg ^ rx_par_odd_reg))) begin
                parity_err_pulse_reg <= 1'b1;
              end else begin
                rx_push_reg <= 1'b1;
                rx_byte_reg <= rx_shift_reg;
              end
            end
            default: rx_state_reg <= RX_IDLE;
          endcase
        end
        if (rx_os_reg == OS_LAST) begin
          case (rx_state_reg)
            RX_START: rx_state_reg <= RX_DATA;
            RX_DATA: begin
              if (rx_idx_reg == 3'd7) rx_state_reg <= rx_par_en_reg ? RX_PARITY : RX_STOP;
              else                    rx_idx_reg   <= rx_idx_reg + 3'd1;
            end
            RX_PARITY: rx_state_reg <= RX_STOP;
            default:   rx_state_reg <= rx_state_reg;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: reads and serial TX frames are
// queued as expectations and checked by independent monitor processes.
module tb_uart_mmio_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  uart_addr = 4'h0;
  logic [31:0] uart_wdata = 32'h0;
  logic        uart_wr_enable = 1'b0;
  logic        uart_rd_enable = 1'b0;
  logic [31:0] uart_rdata;
  logic        uart_irq;
  logic        rx_bit;
  logic        tx_bit;
  logic        loopback = 1'b0;
  logic        rx_drive = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_data_q[$];
  logic        tx_pe_q[$];
  logic        tx_par_q[$];

  always #5 clock = ~clock;
  assign rx_bit = loopback ? tx_bit : rx_drive;

  uart_mmio_fifo #(.FIFO_DEPTH(16), .DEFAULT_DIV(27), .DIV_W(16)) dut (
    .clock(clock), .reset(reset),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wr_enable(uart_wr_enable), .uart_rd_enable(uart_rd_enable),
    .uart_rdata(uart_rdata), .uart_irq(uart_irq),
    .rx_bit(rx_bit), .tx_bit(tx_bit)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    uart_addr = a; uart_wdata = d; uart_wr_enable = 1'b1;
    cyc(1);
    uart_wr_enable = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    uart_addr = a; uart_rd_enable = 1'b1;
    cyc(1);
    uart_rd_enable = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic pe, input logic p);
    tx_data_q.push_back(d); tx_pe_q.push_back(pe); tx_par_q.push_back(p);
  endtask

  // Serial frame driver at BAUD=1 (16 cycles per bit), no parity
  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_drive = 1'b0; cyc(16);
    for (int i = 0; i < 8; i++) begin rx_drive = d[i]; cyc(16); end
    rx_drive = stop; cyc(16);
    rx_drive = 1'b1; cyc(16);
  endtask

  // Read monitor: compares read data while the load strobe is presented
  initial begin : rd_mon
    forever begin
      @(negedge clock);
      if (uart_rd_enable) begin
        if (rd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got 0x%0h, expected no read", uart_rdata);
        end else begin
          $display("read %s addr=0x%0h data=0x%0h expected=0x%0h",
                   rd_name_q[0], uart_addr, uart_rdata, rd_exp_q[0]);
          check(rd_name_q.pop_front(), uart_rdata, rd_exp_q.pop_front());
        end
      end
    end
  end

  // TX monitor: decodes frames off tx_bit at 16 cycles per bit
  initial begin : tx_mon
    logic       prev, st, p, sp, pe, pexp;
    logic [7:0] d, dexp;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && prev && !tx_bit) begin
        if (tx_data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_frame: got a start bit, expected idle line");
          dexp = 8'h0; pe = 1'b0; pexp = 1'b0;
        end else begin
          dexp = tx_data_q.pop_front(); pe = tx_pe_q.pop_front(); pexp = tx_par_q.pop_front();
        end
        repeat (8) @(negedge clock);
        st = tx_bit;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clock);
          d[i] = tx_bit;
        end
        p = 1'b0;
        if (pe) begin
          repeat (16) @(negedge clock);
          p = tx_bit;
        end
        repeat (16) @(negedge clock);
        sp = tx_bit;
        $display("tx frame data=0x%0h parity=%0b stop=%0b expected data=0x%0h parity=%0b",
                 d, p, sp, dexp, pexp);
        check("tx_frame", {21'b0, sp, p, d, st}, {21'b0, 1'b1, pexp, dexp, 1'b0});
      end
      prev = tx_bit;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // 1. Reset state
    check("reset_tx_bit", 32'(tx_bit), 32'h1);
    check("reset_irq", 32'(uart_irq), 32'h0);
    rd(4'h4, 32'h00A, "reset_status");
    rd(4'h8, 32'h003, "reset_ctrl");
    rd(4'hC, 32'd27, "reset_baud");
    rd(4'h0, 32'h0, "empty_data_read");

    wr(4'hC, 32'd1);
    rd(4'hC, 32'd1, "baud_write");
    cyc(40);

    // 2. Loopback of two bytes
    loopback = 1'b1;
    cyc(2);
    expect_tx(8'h55, 1'b0, 1'b0);
    expect_tx(8'hA3, 1'b0, 1'b0);
    wr(4'h0, 32'h55);
    wr(4'h0, 32'hA3);
    cyc(400);
    rd(4'h0, 32'h55, "loop_byte0");
    rd(4'h0, 32'hA3, "loop_byte1");
    rd(4'h4, 32'h00A, "loop_status");

    // 3. Parity bit: odd then even for data 0x01
    loopback = 1'b0;
    wr(4'h8, 32'h0F);
    expect_tx(8'h01, 1'b1, 1'b0);
    wr(4'h0, 32'h01);
    cyc(200);
    wr(4'h8, 32'h07);
    expect_tx(8'h01, 1'b1, 1'b1);
    wr(4'h0, 32'h01);
    cyc(200);

    // 4. TX overflow with transmitter disabled
    wr(4'h8, 32'h02);
    for (int i = 1; i <= 17; i++) wr(4'h0, 32'(8'h10 + i));
    rd(4'h4, 32'h089, "tx_overflow_status");
    wr(4'h4, 32'h80);
    rd(4'h4, 32'h009, "tx_overflow_w1c");
    for (int i = 1; i <= 16; i++) expect_tx(8'(8'h10 + i), 1'b0, 1'b0);
    loopback = 1'b1;
    cyc(2);
    wr(4'h8, 32'h03);
    cyc(2900);
    for (int i = 1; i <= 16; i++) rd(4'h0, 32'(8'h10 + i), $sformatf("drain_%0d", i));
    rd(4'h4, 32'h00A, "drained_status");

    // 5. Framing error then a good byte
    loopback = 1'b0;
    cyc(2);
    send_rx(8'hAA, 1'b0);
    cyc(10);
    rd(4'h4, 32'h02A, "frame_err_status");
    rd(4'h0, 32'h0, "frame_err_discard");
    send_rx(8'h3C, 1'b1);
    cyc(10);
    rd(4'h0, 32'h3C, "rx_good_byte");
    wr(4'h4, 32'h20);
    rd(4'h4, 32'h00A, "frame_err_w1c");

    // 6. RX interrupt and overrun
    wr(4'h8, 32'h13);
    cyc(3);
    check("irq_before_rx", 32'(uart_irq), 32'h0);
    send_rx(8'h41, 1'b1);
    check("irq_after_first", 32'(uart_irq), 32'h1);
    for (int i = 2; i <= 17; i++) send_rx(8'(8'h40 + i), 1'b1);
    rd(4'h4, 32'h016, "overrun_status");
    for (int i = 1; i <= 16; i++) rd(4'h0, 32'(8'h40 + i), $sformatf("irq_drain_%0d", i));
    check("irq_at_last_pop", 32'(uart_irq), 32'h1);
    cyc(1);
    check("irq_dropped", 32'(uart_irq), 32'h0);
    wr(4'h4, 32'h10);
    rd(4'h4, 32'h00A, "overrun_w1c");

    cyc(20);
    check("tx_expect_drained", 32'(tx_data_q.size()), 32'h0);
    check("rd_expect_drained", 32'(rd_exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
